// File: rtl/fir_pkg.sv
// Shared constants and types for the 13-tap transposed-form FIR and its
// run-time coefficient controller.
package fir_pkg;

  localparam int unsigned NTAPS  = 13;
  localparam int unsigned CW     = 8;
  localparam int unsigned AW     = 4;
  localparam int unsigned CENTRE = (NTAPS - 1) / 2;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SETTLE
  } state_e;

  // Identity filter: centre tap = 1, all others 0.
  localparam logic [NTAPS*CW-1:0] COEF_IDENT = (NTAPS*CW)'(1) << (CW * CENTRE);

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register banks with atomic shadow-to-active swap.
// Optional registered readback of the active bank under FIR_COEF_READBACK_EN.
module fir_coef_bank #(
  parameter int unsigned NTAPS = fir_pkg::NTAPS,
  parameter int unsigned CW    = fir_pkg::CW,
  parameter int unsigned AW    = fir_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [CW-1:0] wr_data,
  input  logic                 swap,
  output logic [NTAPS*CW-1:0]  coef_flat
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [AW-1:0]        rd_addr,
  output logic [CW-1:0]        rd_data
`endif
);

  localparam int unsigned CENTRE = (NTAPS - 1) / 2;

  logic signed [CW-1:0] shadow_q [NTAPS];
  logic signed [CW-1:0] active_q [NTAPS];
  logic                 wr_ok;

  assign wr_ok = 32'(wr_addr) < NTAPS;

  // Out-of-range writes are silently dropped; the swap copies every tap at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == CENTRE) ? CW'(1) : '0;
        active_q[k] <= (k == CENTRE) ? CW'(1) : '0;
      end
    end else begin
      if (wr_en && wr_ok) begin
        shadow_q[wr_addr] <= wr_data;
      end
      if (swap) begin
        active_q <= shadow_q;
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_flat
    assign coef_flat[CW*k +: CW] = active_q[k];
  end

`ifdef FIR_COEF_READBACK_EN
  logic rd_ok;

  assign rd_ok = 32'(rd_addr) < NTAPS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_ok ? active_q[rd_addr] : '0;
    end
  end
`endif

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient controller: shadow writes, strobe-aligned atomic commit,
// then a settle window of NTAPS strobes. Optional readback: FIR_COEF_READBACK_EN.
module fir_coef_ctrl #(
  parameter int unsigned NTAPS = fir_pkg::NTAPS,
  parameter int unsigned CW    = fir_pkg::CW,
  parameter int unsigned AW    = fir_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  input  logic                 cfg_last,
  input  logic                 sample_strobe,
  output logic [NTAPS*CW-1:0]  coef_flat,
  output logic                 swap_done,
  output logic                 settled,
  output logic                 addr_err
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [AW-1:0]        rd_addr,
  output logic [CW-1:0]        rd_data
`endif
);

  import fir_pkg::*;

  localparam int unsigned CNT_W = $clog2(NTAPS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             swap_d;
  logic             wr_fire;
  logic             addr_bad;

  assign wr_fire  = cfg_valid && cfg_ready;
  assign addr_bad = 32'(cfg_addr) >= NTAPS;

  // Next-state: commit request, strobe-aligned swap, NTAPS-strobe settle window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_fire && cfg_last) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (sample_strobe) begin
          swap_d  = 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sample_strobe) begin
          if (cnt_q == CNT_W'(NTAPS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cfg_ready <= 1'b1;
      settled   <= 1'b1;
      swap_done <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_ready <= (state_d == IDLE);
      settled   <= (state_d == IDLE);
      swap_done <= swap_d;
      addr_err  <= wr_fire && addr_bad;
    end
  end

  fir_coef_bank #(
    .NTAPS (NTAPS),
    .CW    (CW),
    .AW    (AW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_fire),
    .wr_addr   (cfg_addr),
    .wr_data   (cfg_data),
    .swap      (swap_d),
    .coef_flat (coef_flat)
`ifdef FIR_COEF_READBACK_EN
    ,
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
`endif
  );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_fir_coef_ctrl;

  localparam int NT = 13;
  localparam int W  = 8;

  logic              clk;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_addr;
  logic signed [7:0] cfg_data;
  logic              cfg_last;
  logic              sample_strobe;
  logic [NT*W-1:0]   coef_flat;
  logic              swap_done;
  logic              settled;
  logic              addr_err;
`ifdef FIR_COEF_READBACK_EN
  logic [3:0]        rd_addr;
  logic [7:0]        rd_data;
`endif

  fir_coef_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_last      (cfg_last),
    .sample_strobe (sample_strobe),
    .coef_flat     (coef_flat),
    .swap_done     (swap_done),
    .settled       (settled),
    .addr_err      (addr_err)
`ifdef FIR_COEF_READBACK_EN
    ,
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: commit pending flag plus strobes left in the settle window.
  logic signed [7:0] m_shadow [NT];
  logic signed [7:0] m_active [NT];
  bit                m_pend;
  int                m_left;
  bit                m_swap;
  bit                m_err;
  logic [7:0]        m_rd;

  function automatic bit m_idle();
    return !m_pend && (m_left == 0);
  endfunction

  function automatic logic [NT*W-1:0] m_flat();
    logic [NT*W-1:0] f;
    for (int k = 0; k < NT; k++) f[W*k +: W] = m_active[k];
    return f;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) begin
      m_shadow[k] = (k == 6) ? 8'sd1 : 8'sd0;
      m_active[k] = (k == 6) ? 8'sd1 : 8'sd0;
    end
    m_pend = 0;
    m_left = 0;
    m_swap = 0;
    m_err  = 0;
    m_rd   = 8'd0;
  endfunction

  function automatic void model_step();
    bit         idle;
    logic [7:0] rd_next;
    idle    = m_idle();
    rd_next = 8'd0;
`ifdef FIR_COEF_READBACK_EN
    if (int'(rd_addr) < NT) rd_next = m_active[rd_addr];
`endif
    m_swap = 0;
    m_err  = 0;
    if (cfg_valid && idle) begin
      if (int'(cfg_addr) >= NT) m_err = 1;
      else m_shadow[cfg_addr] = cfg_data;
      if (cfg_last) m_pend = 1;
    end else if (m_pend && sample_strobe) begin
      m_active = m_shadow;
      m_pend   = 0;
      m_left   = NT;
      m_swap   = 1;
    end else if (m_left > 0 && sample_strobe) begin
      m_left = m_left - 1;
    end
    m_rd = rd_next;
  endfunction

  always @(posedge clk) begin
    if (reset) model_step();
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("cfg_ready", 128'(cfg_ready), 128'(m_idle()));
    check("settled", 128'(settled), 128'(m_idle()));
    check("swap_done", 128'(swap_done), 128'(m_swap));
    check("addr_err", 128'(addr_err), 128'(m_err));
    check("coef_flat", 128'(coef_flat), 128'(m_flat()));
`ifdef FIR_COEF_READBACK_EN
    check("rd_data", 128'(rd_data), 128'(m_rd));
`endif
  end

  task automatic drive(input bit v, input int a, input int d, input bit l, input bit s);
    cfg_valid     = v;
    cfg_addr      = 4'(a);
    cfg_data      = 8'(d);
    cfg_last      = l;
    sample_strobe = s;
    @(negedge clk);
  endtask

  function automatic logic [7:0] tap(input int k);
    return coef_flat[W*k +: W];
  endfunction

  logic [NT*W-1:0] ident_lit;
  logic [NT*W-1:0] ramp_lit;

  initial begin
    model_reset();
    reset = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_last = 1'b0; sample_strobe = 1'b0;
`ifdef FIR_COEF_READBACK_EN
    rd_addr = 4'd6;
`endif
    ident_lit = '0;
    ident_lit[55:48] = 8'h01;
    for (int k = 0; k < NT; k++) ramp_lit[W*k +: W] = 8'(k + 1);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("lit_reset_coef", 128'(coef_flat), 128'(ident_lit));
    check("lit_reset_settled", 128'(settled), 128'd1);
    check("lit_reset_ready", 128'(cfg_ready), 128'd1);

    // Full load, then hold strobe low.
    for (int k = 0; k < NT; k++) drive(1, k, k + 1, k == NT - 1, 0);
    repeat (10) drive(0, 0, 0, 0, 0);
    check("lit_pend_coef", 128'(coef_flat), 128'(ident_lit));
    check("lit_pend_ready", 128'(cfg_ready), 128'd0);
    drive(0, 0, 0, 0, 1);
    check("lit_swap_pulse", 128'(swap_done), 128'd1);
    check("lit_swap_coef", 128'(coef_flat), 128'(ramp_lit));
    check("lit_swap_settled", 128'(settled), 128'd0);
    drive(0, 0, 0, 0, 0);
    check("lit_swap_one_cycle", 128'(swap_done), 128'd0);

    repeat (12) drive(0, 0, 0, 0, 1);
    check("lit_settle12_settled", 128'(settled), 128'd0);
    check("lit_settle12_ready", 128'(cfg_ready), 128'd0);
    drive(0, 0, 0, 0, 1);
    check("lit_settle13_settled", 128'(settled), 128'd1);
    check("lit_settle13_ready", 128'(cfg_ready), 128'd1);

    // Strobe coincident with the commit write must not swap.
    drive(1, 3, -5, 1, 1);
    check("lit_simul_noswap", 128'(swap_done), 128'd0);
    check("lit_simul_tap3_old", 128'(tap(3)), 128'd4);
    drive(0, 0, 0, 0, 1);
    check("lit_simul_swap", 128'(swap_done), 128'd1);
    check("lit_simul_tap3_new", 128'(tap(3)), 128'hFB);
    check("lit_simul_tap2", 128'(tap(2)), 128'd3);
    check("lit_simul_tap12", 128'(tap(12)), 128'd13);
    repeat (13) drive(0, 0, 0, 0, 1);

    // Out-of-range write still commits.
    drive(1, 14, 99, 1, 0);
    check("lit_oor_err", 128'(addr_err), 128'd1);
    drive(0, 0, 0, 0, 1);
    check("lit_oor_err_clear", 128'(addr_err), 128'd0);
    check("lit_oor_swap", 128'(swap_done), 128'd1);
    check("lit_oor_tap3", 128'(tap(3)), 128'hFB);
    check("lit_oor_tap0", 128'(tap(0)), 128'd1);

    // Reset while settling.
    repeat (5) drive(0, 0, 0, 0, 1);
    check("lit_mid_settled", 128'(settled), 128'd0);
    #2;
    reset = 1'b0;
    model_reset();
`ifdef FIR_COEF_READBACK_EN
    rd_addr = 4'd6;
`endif
    @(negedge clk);
    check("lit_rst_coef", 128'(coef_flat), 128'(ident_lit));
    check("lit_rst_settled", 128'(settled), 128'd1);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
`ifdef FIR_COEF_READBACK_EN
    check("lit_rst_rd6", 128'(rd_data), 128'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
`ifdef FIR_COEF_READBACK_EN
      rd_addr = 4'($urandom_range(0, 15));
`endif
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), int'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
